matrix_scan_scheduler: RTL and testbench

- Shared column-scan controller for the two 5x7 LED matrices: the level/alarm page (N) and the irrigation-mode page (R).
- Generates the column scan timing from the system clock and inserts anti-ghosting blanking.
- Arbitrates which page owns the row drive at each frame boundary; alarm/error takes priority.
- Sits between the page pattern generators and the matrix pins; the pattern generators become combinational on col_idx.

---
 rtl/matrix_scan_scheduler.sv | 216 +++++++++++++++++++++
 tb/tb_matrix_scan_scheduler.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_scan_scheduler.sv
// matrix_scan_scheduler
// Shared column-scan controller for two 5x7 LED matrix pages: the level/alarm
// page (N) and the irrigation-mode page (R). It generates the column scan timing,
// blanks the start of each column slot against ghosting, and decides which page
// owns the row drive. Ownership changes only at frame boundaries.
//
// Optional feature: define URGENT_BLINK_EN to blink the N page's rows on
// alternate frames while urgent is held.
//
// Ports:
//   clk         in   system clock, rising edge
//   rstn        in   synchronous reset, active high
//   en          in   scan enable; 0 freezes the scan and blanks the outputs
//   req_n       in   N page requests the display
//   req_r       in   R page requests the display
//   urgent      in   alarm/error active; forces the N page at the next frame
//   lin_n[6:0]  in   N-page rows for the current col_idx (bit0 = row 1)
//   lin_r[6:0]  in   R-page rows for the current col_idx
//   col_idx[2:0] out current column, 0..4
//   col[4:0]    out  one-hot column drive (bit0 = column 1)
//   lin[6:0]    out  row drive
//   gnt_n       out  N page owns the display
//   gnt_r       out  R page owns the display
//   frame_done  out  one-cycle pulse after column 4 completes
module matrix_scan_scheduler #(
    parameter int unsigned PRESC_DIV   = 1000,
    parameter int unsigned BLANK_CYC   = 4,
    parameter int unsigned PAGE_FRAMES = 50
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       en,
    input  logic       req_n,
    input  logic       req_r,
    input  logic       urgent,
    input  logic [6:0] lin_n,
    input  logic [6:0] lin_r,
    output logic [2:0] col_idx,
    output logic [4:0] col,
    output logic [6:0] lin,
    output logic       gnt_n,
    output logic       gnt_r,
    output logic       frame_done
);

    // Wide enough to hold PAGE_FRAMES itself, since the count saturates there.
    localparam int unsigned FCW = (PAGE_FRAMES < 2) ? 1 : $clog2(PAGE_FRAMES + 1);
    localparam logic [15:0] PRESC_LAST = 16'(PRESC_DIV - 1);
    localparam logic [15:0] BLANK_LIM  = 16'(BLANK_CYC);
    localparam logic [FCW-1:0] FC_MAX  = FCW'(PAGE_FRAMES);

    typedef enum logic [1:0] {
        StIdle,
        StShowN,
        StShowR
    } state_e;

    logic [15:0]    presc_q, presc_d;
    logic [2:0]     col_idx_q, col_idx_d;
    state_e         state_q, state_d;
    logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
    logic [4:0]     col_q, col_d;
    logic [6:0]     lin_q, lin_d;
    logic           gnt_n_q, gnt_n_d;
    logic           gnt_r_q, gnt_r_d;
    logic           frame_done_q, frame_done_d;

    logic   presc_last;
    logic   tick;
    logic   cur_req;
    logic   oth_req;
    state_e oth_state;
    logic   fc_full;
    logic   blank;

`ifdef URGENT_BLINK_EN
    logic blink_q, blink_d;
`endif

    assign presc_last = (presc_q == PRESC_LAST);
    // Frame boundary: last prescaler count of column 4, only while scanning.
    assign tick       = en && presc_last && (col_idx_q == 3'd4);
    // Holding the page for one more frame would reach the PAGE_FRAMES quota.
    assign fc_full    = (32'(frame_cnt_q) + 32'd1) >= PAGE_FRAMES;

    // Scan timing: prescaler and column index.
    always_comb begin
        presc_d   = presc_q;
        col_idx_d = col_idx_q;
        if (en) begin
            if (presc_last) begin
                presc_d   = 16'd0;
                col_idx_d = (col_idx_q == 3'd4) ? 3'd0 : col_idx_q + 3'd1;
            end else begin
                presc_d = presc_q + 16'd1;
            end
        end
    end

    // Page arbitration, evaluated only at frame boundaries.
    always_comb begin
        state_d   = state_q;
        cur_req   = 1'b0;
        oth_req   = 1'b0;
        oth_state = StIdle;
        case (state_q)
            StShowN: begin
                cur_req   = req_n;
                oth_req   = req_r;
                oth_state = StShowR;
            end
            StShowR: begin
                cur_req   = req_r;
                oth_req   = req_n;
                oth_state = StShowN;
            end
            default: ;
        endcase

        if (tick) begin
            if (urgent) begin
                state_d = StShowN;
            end else if (state_q == StIdle) begin
                // N wins a tie out of idle.
                state_d = req_n ? StShowN : (req_r ? StShowR : StIdle);
            end else if (cur_req && oth_req && fc_full) begin
                state_d = oth_state;
            end else if (cur_req) begin
                state_d = state_q;
            end else if (oth_req) begin
                state_d = oth_state;
            end else begin
                state_d = StIdle;
            end
        end

        frame_cnt_d = frame_cnt_q;
        if (state_d != state_q) begin
            frame_cnt_d = '0;
        end else if (tick && (state_q != StIdle) && (frame_cnt_q != FC_MAX)) begin
            frame_cnt_d = frame_cnt_q + FCW'(1);
        end

        gnt_n_d      = (state_d == StShowN);
        gnt_r_d      = (state_d == StShowR);
        frame_done_d = tick;
    end

`ifdef URGENT_BLINK_EN
    always_comb begin
        blink_d = blink_q;
        if (tick) begin
            blink_d = urgent ? ~blink_q : 1'b0;
        end
    end
`endif

    // Column/row drive, registered one cycle behind the scan counters.
    always_comb begin
        blank = (presc_q < BLANK_LIM) || (state_q == StIdle) || !en;
        col_d = 5'd0;
        lin_d = 7'd0;
        if (!blank) begin
            col_d = 5'd1 << col_idx_q;
            lin_d = (state_q == StShowR) ? lin_r : lin_n;
`ifdef URGENT_BLINK_EN
            // Dark frame of the urgent blink; the columns keep scanning.
            if ((state_q == StShowN) && blink_q) begin
                lin_d = 7'd0;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            presc_q      <= 16'd0;
            col_idx_q    <= 3'd0;
            state_q      <= StIdle;
            frame_cnt_q  <= '0;
            col_q        <= 5'd0;
            lin_q        <= 7'd0;
            gnt_n_q      <= 1'b0;
            gnt_r_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            col_idx_q    <= col_idx_d;
            state_q      <= state_d;
            frame_cnt_q  <= frame_cnt_d;
            col_q        <= col_d;
            lin_q        <= lin_d;
            gnt_n_q      <= gnt_n_d;
            gnt_r_q      <= gnt_r_d;
            frame_done_q <= frame_done_d;
        end
    end

`ifdef URGENT_BLINK_EN
    always_ff @(posedge clk) begin
        if (rstn) begin
            blink_q <= 1'b0;
        end else begin
            blink_q <= blink_d;
        end
    end
`endif

    assign col_idx    = col_idx_q;
    assign col        = col_q;
    assign lin        = lin_q;
    assign gnt_n      = gnt_n_q;
    assign gnt_r      = gnt_r_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_matrix_scan_scheduler.sv
// Self-checking bench for matrix_scan_scheduler (PRESC_DIV=4, BLANK_CYC=1,
// PAGE_FRAMES=2, so one frame is 20 cycles). Cycle k counts clock edges after
// the reset edge; expected output words are queued before each edge and
// compared 1 time unit after it.
module tb_matrix_scan_scheduler;

    localparam int PD = 4;
    localparam int BC = 1;
    localparam int PF = 2;
    localparam int FR = 5 * PD;
    localparam int StI = 0;
    localparam int StN = 1;
    localparam int StR = 2;

    logic       clk;
    logic       rstn;
    logic       en;
    logic       req_n;
    logic       req_r;
    logic       urgent;
    logic [6:0] lin_n;
    logic [6:0] lin_r;
    logic [2:0] col_idx;
    logic [4:0] col;
    logic [6:0] lin;
    logic       gnt_n;
    logic       gnt_r;
    logic       frame_done;

    // {col_idx, col, lin, gnt_n, gnt_r, frame_done}
    logic [17:0] obs;
    assign obs = {col_idx, col, lin, gnt_n, gnt_r, frame_done};

    logic [17:0] sb_q[$];
    int checks_total  = 0;
    int checks_passed = 0;

    matrix_scan_scheduler #(
        .PRESC_DIV  (PD),
        .BLANK_CYC  (BC),
        .PAGE_FRAMES(PF)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .en        (en),
        .req_n     (req_n),
        .req_r     (req_r),
        .urgent    (urgent),
        .lin_n     (lin_n),
        .lin_r     (lin_r),
        .col_idx   (col_idx),
        .col       (col),
        .lin       (lin),
        .gnt_n     (gnt_n),
        .gnt_r     (gnt_r),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Expected output word after edge k of an uninterrupted scan. sb is the page
    // owning the frame that edge k closes out, sa the page granted after edge k.
    function automatic logic [17:0] predict(int k, int sb, int sa, logic [6:0] ln,
                                            logic [6:0] lr, bit lin_off);
        int presc;
        int ci;
        logic [4:0] one;
        logic [4:0] c;
        logic [6:0] l;
        logic [2:0] idx;
        presc = (k - 1) % PD;
        ci    = ((k - 1) / PD) % 5;
        one   = 5'd1;
        c     = (presc >= BC && sb != StI) ? (one << ci) : 5'd0;
        l     = (c != 5'd0 && !lin_off) ? ((sb == StR) ? lr : ln) : 7'd0;
        idx   = 3'((k / PD) % 5);
        return {idx, c, l, sa == StN, sa == StR, (k % FR) == 0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rstn   = 1'b1;
        en     = 1'b0;
        req_n  = 1'b0;
        req_r  = 1'b0;
        urgent = 1'b0;
        step();
        rstn = 1'b0;
    endtask

    task automatic test_reset();
        logic [17:0] exp_v;
        // Reset must dominate even with every input active.
        rstn   = 1'b1;
        en     = 1'b1;
        req_n  = 1'b1;
        req_r  = 1'b1;
        urgent = 1'b1;
        lin_n  = 7'h7F;
        lin_r  = 7'h7F;
        for (int i = 0; i < 2; i++) begin
            sb_q.push_back(18'd0);
            step();
            exp_v = sb_q.pop_front();
            checks_total++;
            if (obs !== exp_v) $display("FAIL reset i=%0d got=%h exp=%h", i, obs, exp_v);
            else checks_passed++;
        end
        rstn = 1'b0;
    endtask

    task automatic test_single_page();
        int g[3] = '{StI, StN, StN};
        logic [17:0] exp_v;
        apply_reset();
        en    = 1'b1;
        req_n = 1'b1;
        lin_n = 7'h55;
        lin_r = 7'h2A;
        for (int k = 1; k <= 45; k++) begin
            sb_q.push_back(predict(k, g[(k - 1) / FR], g[k / FR], lin_n, lin_r, 1'b0));
            step();
            exp_v = sb_q.pop_front();
            checks_total++;
            if (obs !== exp_v) $display("FAIL single_page k=%0d got=%h exp=%h", k, obs, exp_v);
            else checks_passed++;
        end
    endtask

    task automatic test_alternate();
        int g[8] = '{StI, StN, StN, StR, StR, StN, StN, StI};
        logic [17:0] exp_v;
        apply_reset();
        en    = 1'b1;
        req_n = 1'b1;
        req_r = 1'b1;
        lin_n = 7'h55;
        lin_r = 7'h2A;
        for (int k = 1; k <= 145; k++) begin
            // Drop both requests mid-frame; the frame must run to its end.
            if (k == 126) begin
                req_n = 1'b0;
                req_r = 1'b0;
            end
            sb_q.push_back(predict(k, g[(k - 1) / FR], g[k / FR], lin_n, lin_r, 1'b0));
            step();
            exp_v = sb_q.pop_front();
            checks_total++;
            if (obs !== exp_v) $display("FAIL alternate k=%0d got=%h exp=%h", k, obs, exp_v);
            else checks_passed++;
        end
    endtask

    task automatic test_urgent();
        int g[7] = '{StI, StR, StN, StN, StN, StN, StR};
        logic [17:0] exp_v;
        bit off;
        apply_reset();
        en    = 1'b1;
        req_r = 1'b1;
        lin_n = 7'h7F;
        lin_r = 7'h2A;
        for (int k = 1; k <= 125; k++) begin
            if (k == 26) begin
                urgent = 1'b1;
                req_n  = 1'b1;
            end
            if (k == 106) urgent = 1'b0;
`ifdef URGENT_BLINK_EN
            off = ((k - 1) / FR == 2) || ((k - 1) / FR == 4);
`else
            off = 1'b0;
`endif
            sb_q.push_back(predict(k, g[(k - 1) / FR], g[k / FR], lin_n, lin_r, off));
            step();
            exp_v = sb_q.pop_front();
            checks_total++;
            if (obs !== exp_v) $display("FAIL urgent k=%0d got=%h exp=%h", k, obs, exp_v);
            else checks_passed++;
        end
        req_n = 1'b0;
        req_r = 1'b0;
    endtask

    task automatic test_en_pause();
        int g[4] = '{StI, StN, StN, StN};
        logic [17:0] exp_v;
        apply_reset();
        en    = 1'b1;
        req_n = 1'b1;
        lin_n = 7'h55;
        lin_r = 7'h2A;
        for (int k = 1; k <= 30; k++) begin
            sb_q.push_back(predict(k, g[(k - 1) / FR], g[k / FR], lin_n, lin_r, 1'b0));
            step();
            exp_v = sb_q.pop_front();
            checks_total++;
            if (obs !== exp_v) $display("FAIL en_pre k=%0d got=%h exp=%h", k, obs, exp_v);
            else checks_passed++;
        end
        // Paused mid-slot at column 2: blank drive, frozen index, grant held.
        en = 1'b0;
        for (int p = 0; p < 13; p++) begin
            sb_q.push_back({3'd2, 5'd0, 7'd0, 1'b1, 1'b0, 1'b0});
            step();
            exp_v = sb_q.pop_front();
            checks_total++;
            if (obs !== exp_v) $display("FAIL en_hold p=%0d got=%h exp=%h", p, obs, exp_v);
            else checks_passed++;
        end
        en = 1'b1;
        for (int k = 31; k <= 62; k++) begin
            sb_q.push_back(predict(k, g[(k - 1) / FR], g[k / FR], lin_n, lin_r, 1'b0));
            step();
            exp_v = sb_q.pop_front();
            checks_total++;
            if (obs !== exp_v) $display("FAIL en_resume k=%0d got=%h exp=%h", k, obs, exp_v);
            else checks_passed++;
        end
    endtask

    task automatic test_reset_mid();
        int g[2] = '{StI, StN};
        logic [17:0] exp_v;
        apply_reset();
        en    = 1'b1;
        req_n = 1'b1;
        lin_n = 7'h55;
        lin_r = 7'h2A;
        for (int k = 1; k <= 33; k++) begin
            sb_q.push_back(predict(k, g[(k - 1) / FR], g[k / FR], lin_n, lin_r, 1'b0));
            step();
            exp_v = sb_q.pop_front();
            checks_total++;
            if (obs !== exp_v) $display("FAIL rst_pre k=%0d got=%h exp=%h", k, obs, exp_v);
            else checks_passed++;
        end
        // One-cycle reset at column 3 of a SHOW_N frame.
        rstn = 1'b1;
        sb_q.push_back(18'd0);
        step();
        exp_v = sb_q.pop_front();
        checks_total++;
        if (obs !== exp_v) $display("FAIL rst_mid got=%h exp=%h", obs, exp_v);
        else checks_passed++;
        rstn = 1'b0;
        // Scan restarts from scratch: idle for a full frame, no stray frame_done.
        for (int k = 1; k <= 22; k++) begin
            sb_q.push_back(predict(k, g[(k - 1) / FR], g[k / FR], lin_n, lin_r, 1'b0));
            step();
            exp_v = sb_q.pop_front();
            checks_total++;
            if (obs !== exp_v) $display("FAIL rst_post k=%0d got=%h exp=%h", k, obs, exp_v);
            else checks_passed++;
        end
    endtask

    initial begin
        rstn   = 1'b1;
        en     = 1'b0;
        req_n  = 1'b0;
        req_r  = 1'b0;
        urgent = 1'b0;
        lin_n  = 7'd0;
        lin_r  = 7'd0;
        test_reset();
        test_single_page();
        test_alternate();
        test_urgent();
        test_en_pause();
        test_reset_mid();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
